mode_ctrl: RTL and testbench
============================

Name: mode_ctrl

Overview:
- Top-level function scheduler for the ChronoX display/key path.
- Owns the current function mode (clock, stopwatch, timer, alarm), routes each key event from the key scanner to exactly one function block, and muxes that block's 21-bit display word to the display driver.
- Arbitrates asynchronous alert requests (timer expiry, alarm match) round-robin. It preempts the display until the alert is acknowledged by a key press or times out.

Parameters:
- NUM_MODES, 4, number of function blocks (2..4); mode index 0 after reset.
- DATA_W, 21, width of each display word.
- MODE_KEY, 3'd1, key code (S1) that advances the mode.
- ALERT_CYCLES, 32'd500_000_000, alert auto-timeout in clk cycles (10 s at 50 MHz).
- BLINK_CYCLES, 25'd25_000_000, half-period of the blink output in clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- key_val  input  3  key code, 0 = none, 1..4 = S1..S4; nonzero for exactly one cycle per press
- data_in  input  DATA_W*NUM_MODES  display words; slice i belongs to mode i
- alert_req  input  NUM_MODES  level request per mode, held until acknowledged
- key_route  output  3*NUM_MODES  per-mode key code; slice i carries the key or 0
- data_out  output  DATA_W  registered display word
- mode  output  2  current user-selected mode
- disp_mode  output  2  mode currently shown (mode, or the granted alert)
- mode_chg  output  1  one-cycle pulse on each mode advance
- alert_ack  output  NUM_MODES  one-hot, one-cycle acknowledge
- blink  output  1  display blink enable, active only during ALERT

Behaviour:
- Reset values: all outputs 0, state NORMAL, timers 0; last_grant = NUM_MODES-1, so the first arbitration scan starts at mode 0.
- Reset mid-operation aborts any alert immediately. No ack is issued.
- FSM states: NORMAL, ALERT.
- NORMAL, key == MODE_KEY:
  - mode <= (mode+1) wrapping from NUM_MODES-1 to 0; mode_chg = 1 for the next cycle.
  - The key is not forwarded.
- NORMAL, other nonzero key: registered onto key_route slice [mode], 1-cycle latency. All other slices are 0. Every slice returns to 0 the following cycle.
- NORMAL, any alert_req bit set:
  - Grant the first set bit scanning from last_grant+1 upward, with wrap.
  - alert_mode <= grant; last_grant <= grant; next state ALERT.
  - Clear the timeout and blink counters; set blink = 1.
- Key and alert in the same NORMAL cycle: the key is processed normally (mode advance or forward) and ALERT is also entered. saved mode = the post-key mode.
- ALERT:
  - mode output is frozen.
  - disp_mode = alert_mode.
  - blink toggles every BLINK_CYCLES.
- ALERT, any nonzero key (including MODE_KEY): alert_ack[alert_mode] = 1 for one cycle. The key is consumed, not forwarded. Return to NORMAL.
- ALERT, timeout counter reaches ALERT_CYCLES-1: same ack; return to NORMAL.
- ALERT, alert_req[alert_mode] drops without a key: return to NORMAL with no ack.
- Priority within ALERT: key > timeout > request drop.
- Other alerts pending at return are re-arbitrated from NORMAL on the next cycle. Fairness comes from last_grant.
- On every return to NORMAL: blink = 0; disp_mode = mode.
- data_out <= data_in slice [disp_mode] every cycle (1-cycle latency). data_out tracks the live slice continuously; it is not sampled once.
- mode values >= NUM_MODES are unreachable. disp_mode equals mode whenever in NORMAL.

Optional Feature:
- Macro: MODE_LOCK_EN.
- When defined:
  - Adds input lock [NUM_MODES-1:0].
  - In NORMAL, if lock[mode] = 1, MODE_KEY is forwarded to key_route[mode] as an ordinary key. The mode does not advance and there is no mode_chg. Used so, e.g., a running timer-set sequence cannot be left.
  - Alerts still preempt regardless of lock.
- When undefined: no lock port; MODE_KEY always advances the mode.

Test Plan:
- Bench parameters: NUM_MODES=4, ALERT_CYCLES=20, BLINK_CYCLES=4.
- Reset, then four S1 pulses -> mode 1,2,3,0; mode_chg pulses 4 times; key_route stays all-zero.
- mode=1, key_val=2 for one cycle -> next cycle key_route[5:3]=2, other slices 0; then all 0. data_in slice1 = 21'h1ABCD appears on data_out one cycle after mode becomes 1.
- mode=0, alert_req=4'b1010 -> grant 1 first (disp_mode=1, blink toggles every 4 cycles); key 3 -> alert_ack=4'b0010, nothing forwarded. Next re-arbitration grants 3; after 20 idle cycles, alert_ack=4'b1000 by timeout; mode remains 0.
- S1 and alert_req[2] in the same cycle at mode=3 -> mode becomes 0 and ALERT is entered with disp_mode=2; after ack, disp_mode returns to 0.
- In ALERT on mode 2, drop alert_req[2] -> NORMAL next cycle, alert_ack stays 0. Assert rst low mid-ALERT -> all outputs 0 immediately, no ack.
- MODE_LOCK_EN defined, lock=4'b0001, mode=0, S1 -> key_route[2:0]=1, mode stays 0. With lock=0, S1 -> mode=1.

Source files
------------

// File: rtl/mode_ctrl.sv
// mode_ctrl: ChronoX function scheduler. Handles mode select, key routing, display mux and round-robin alert preemption.
// Optional build macro MODE_LOCK_EN adds a per-mode lock input that turns MODE_KEY into an ordinary forwarded key.
module mode_ctrl #(
   parameter int unsigned NUM_MODES    = 4,
   parameter int unsigned DATA_W       = 21,
   parameter logic [2:0]  MODE_KEY     = 3'd1,
   parameter logic [31:0] ALERT_CYCLES = 32'd500_000_000,
   parameter logic [24:0] BLINK_CYCLES = 25'd25_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2:0]                    key_val,
   input  logic [DATA_W*NUM_MODES-1:0]   data_in,
   input  logic [NUM_MODES-1:0]          alert_req,
`ifdef MODE_LOCK_EN
   input  logic [NUM_MODES-1:0]          lock,
`endif
   output logic [3*NUM_MODES-1:0]        key_route,
   output logic [DATA_W-1:0]             data_out,
   output logic [1:0]                    mode,
   output logic [1:0]                    disp_mode,
   output logic                          mode_chg,
   output logic [NUM_MODES-1:0]          alert_ack,
   output logic                          blink
);
   typedef enum logic {NORMAL, ALERT} state_e;

   state_e                 state_q, state_d;
   logic [1:0]             mode_q, mode_d, alert_mode_q, alert_mode_d, last_grant_q, last_grant_d;
   logic [31:0]            tmo_cnt_q, tmo_cnt_d;
   logic [24:0]            blink_cnt_q, blink_cnt_d;
   logic                   blink_q, blink_d, mode_chg_q, mode_chg_d;
   logic [3*NUM_MODES-1:0] key_route_q, key_route_d;
   logic [NUM_MODES-1:0]   ack_q, ack_d, req_live;
   logic [DATA_W-1:0]      data_q, data_d;
   logic [1:0]             disp_sel, grant;
   logic                   grant_vld, req_cur, locked, tmo_hit, key_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= NORMAL;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q       <= '0;
         alert_mode_q <= '0;
         last_grant_q <= 2'(NUM_MODES-1);
         tmo_cnt_q    <= '0;
         blink_cnt_q  <= '0;
         blink_q      <= 1'b0;
         mode_chg_q   <= 1'b0;
         key_route_q  <= '0;
         ack_q        <= '0;
         data_q       <= '0;
      end else begin
         mode_q       <= mode_d;
         alert_mode_q <= alert_mode_d;
         last_grant_q <= last_grant_d;
         tmo_cnt_q    <= tmo_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
         mode_chg_q   <= mode_chg_d;
         key_route_q  <= key_route_d;
         ack_q        <= ack_d;
         data_q       <= data_d;
      end
   end

   // The ack is registered, so the acknowledged request is still high for one cycle; mask it from arbitration.
   always_comb begin
      req_live  = alert_req & ~ack_q;
      grant_vld = 1'b0;
      grant     = '0;
      for (int unsigned j = 0; j < NUM_MODES; j++)
         if (!grant_vld && req_live[j] && (2'(j) > last_grant_q)) begin
            grant_vld = 1'b1;
            grant     = 2'(j);
         end
      for (int unsigned j = 0; j < NUM_MODES; j++)
         if (!grant_vld && req_live[j]) begin
            grant_vld = 1'b1;
            grant     = 2'(j);
         end
      req_cur = 1'b0;
      locked  = 1'b0;
      for (int unsigned j = 0; j < NUM_MODES; j++) begin
         if (alert_mode_q == 2'(j)) req_cur = alert_req[j];
`ifdef MODE_LOCK_EN
         if (mode_q == 2'(j)) locked = lock[j];
`endif
      end
      tmo_hit  = (tmo_cnt_q == ALERT_CYCLES - 32'd1);
      key_hit  = (key_val != 3'd0);
      disp_sel = (state_q == ALERT) ? alert_mode_q : mode_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         NORMAL:  if (grant_vld) state_d = ALERT;
         ALERT:   if (key_hit || tmo_hit || !req_cur) state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   always_comb begin
      mode_d       = mode_q;
      alert_mode_d = alert_mode_q;
      last_grant_d = last_grant_q;
      tmo_cnt_d    = tmo_cnt_q;
      blink_cnt_d  = blink_cnt_q;
      blink_d      = blink_q;
      mode_chg_d   = 1'b0;
      key_route_d  = '0;
      ack_d        = '0;
      data_d       = '0;
      for (int unsigned j = 0; j < NUM_MODES; j++)
         if (disp_sel == 2'(j)) data_d = data_in[j*DATA_W +: DATA_W];
      case (state_q)
         NORMAL: begin
            if (key_val == MODE_KEY && !locked) begin
               mode_d     = (mode_q == 2'(NUM_MODES-1)) ? 2'd0 : mode_q + 2'd1;
               mode_chg_d = 1'b1;
            end else if (key_hit) begin
               for (int unsigned j = 0; j < NUM_MODES; j++)
                  if (mode_q == 2'(j)) key_route_d[j*3 +: 3] = key_val;
            end
            if (grant_vld) begin
               alert_mode_d = grant;
               last_grant_d = grant;
               tmo_cnt_d    = '0;
               blink_cnt_d  = '0;
               blink_d      = 1'b1;
            end
         end
         ALERT: begin
            if (key_hit || tmo_hit)
               for (int unsigned j = 0; j < NUM_MODES; j++)
                  if (alert_mode_q == 2'(j)) ack_d[j] = 1'b1;
            if (state_d == NORMAL) begin
               tmo_cnt_d   = '0;
               blink_cnt_d = '0;
               blink_d     = 1'b0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
               if (blink_cnt_q == BLINK_CYCLES - 25'd1) begin
                  blink_cnt_d = '0;
                  blink_d     = !blink_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + 25'd1;
               end
            end
         end
         default: ;
      endcase
   end

   assign key_route = key_route_q;
   assign data_out  = data_q;
   assign mode      = mode_q;
   assign disp_mode = disp_sel;
   assign mode_chg  = mode_chg_q;
   assign alert_ack = ack_q;
   assign blink     = blink_q;
endmodule

// File: tb/tb_mode_ctrl.sv
// Directed self-checking bench for mode_ctrl: mode advance, key routing, display mux, alert arbitration, timeout, reset.
module tb_mode_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  key_val;
   logic [83:0] data_in;
   logic [3:0]  alert_req;
   logic [11:0] key_route;
   logic [20:0] data_out;
   logic [1:0]  mode, disp_mode;
   logic        mode_chg, blink;
   logic [3:0]  alert_ack;
`ifdef MODE_LOCK_EN
   logic [3:0]  lock = 4'b0000;
`endif
   int checks = 0;
   int errors = 0;

   mode_ctrl #(.NUM_MODES(4), .DATA_W(21), .MODE_KEY(3'd1), .ALERT_CYCLES(32'd20), .BLINK_CYCLES(25'd4)) dut (
      .clk(clk), .rst(rst), .key_val(key_val), .data_in(data_in), .alert_req(alert_req),
`ifdef MODE_LOCK_EN
      .lock(lock),
`endif
      .key_route(key_route), .data_out(data_out), .mode(mode), .disp_mode(disp_mode),
      .mode_chg(mode_chg), .alert_ack(alert_ack), .blink(blink));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] k);
      key_val = k;
      step();
      key_val = 3'd0;
   endtask

   task automatic test_reset();
      rst = 1'b0; key_val = 3'd0; alert_req = 4'b0;
      data_in = {21'h15555, 21'h0F0F0, 21'h1ABCD, 21'h00123};
      step(); step();
      checks++; if ({key_route, data_out, mode, disp_mode, mode_chg, alert_ack, blink} !== 43'd0) begin
         errors++; $display("FAIL reset_outputs got %h exp 0", {key_route, data_out, mode, disp_mode, mode_chg, alert_ack, blink}); end
      rst = 1'b1;
      step();
      checks++; if (data_out !== 21'h00123) begin errors++; $display("FAIL reset_data0 got %h exp 00123", data_out); end
   endtask

   task automatic test_mode_advance();
      logic [1:0] exp_m;
      for (int unsigned k = 1; k <= 4; k++) begin
         press(3'd1);
         exp_m = 2'(k % 4);
         checks++; if (mode !== exp_m) begin errors++; $display("FAIL adv_mode got %0d exp %0d", mode, exp_m); end
         checks++; if (mode_chg !== 1'b1) begin errors++; $display("FAIL adv_chg got %b exp 1", mode_chg); end
         checks++; if (key_route !== 12'd0) begin errors++; $display("FAIL adv_route got %h exp 000", key_route); end
         step();
         checks++; if (mode_chg !== 1'b0) begin errors++; $display("FAIL adv_chg_clr got %b exp 0", mode_chg); end
      end
   endtask

   task automatic test_key_route();
      press(3'd1);
      checks++; if (data_out !== 21'h00123) begin errors++; $display("FAIL route_data_lat got %h exp 00123", data_out); end
      step();
      checks++; if (data_out !== 21'h1ABCD) begin errors++; $display("FAIL route_data1 got %h exp 1ABCD", data_out); end
      press(3'd2);
      checks++; if (key_route !== 12'h010) begin errors++; $display("FAIL route_fwd got %h exp 010", key_route); end
      checks++; if (mode !== 2'd1) begin errors++; $display("FAIL route_mode got %0d exp 1", mode); end
      step();
      checks++; if (key_route !== 12'h000) begin errors++; $display("FAIL route_clr got %h exp 000", key_route); end
      data_in[41:21] = 21'h0AAAA;
      step();
      checks++; if (data_out !== 21'h0AAAA) begin errors++; $display("FAIL route_live got %h exp 0AAAA", data_out); end
      press(3'd1); press(3'd1); press(3'd1);
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL route_back0 got %0d exp 0", mode); end
   endtask

   task automatic test_alert_rr();
      int n;
      logic exp_b;
      alert_req = 4'b1010;
      step();
      checks++; if (disp_mode !== 2'd1) begin errors++; $display("FAIL rr_grant1 got %0d exp 1", disp_mode); end
      checks++; if (blink !== 1'b1) begin errors++; $display("FAIL rr_blink_set got %b exp 1", blink); end
      for (int i = 1; i <= 8; i++) begin
         step();
         exp_b = (i >= 4 && i <= 7) ? 1'b0 : 1'b1;
         checks++; if (blink !== exp_b) begin errors++; $display("FAIL rr_blink%0d got %b exp %b", i, blink, exp_b); end
      end
      checks++; if (data_out !== 21'h0AAAA) begin errors++; $display("FAIL rr_data got %h exp 0AAAA", data_out); end
      press(3'd3);
      checks++; if (alert_ack !== 4'b0010) begin errors++; $display("FAIL rr_ack_key got %b exp 0010", alert_ack); end
      checks++; if (key_route !== 12'd0) begin errors++; $display("FAIL rr_consume got %h exp 000", key_route); end
      checks++; if (disp_mode !== 2'd0 || blink !== 1'b0) begin
         errors++; $display("FAIL rr_return got disp %0d blink %b exp disp 0 blink 0", disp_mode, blink); end
      alert_req = 4'b1000;
      step();
      checks++; if (disp_mode !== 2'd3) begin errors++; $display("FAIL rr_grant3 got %0d exp 3", disp_mode); end
      checks++; if (alert_ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_clr got %b exp 0000", alert_ack); end
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (alert_ack !== 4'b0000) begin n = i; break; end
      end
      checks++; if (n != 20) begin errors++; $display("FAIL rr_tmo_cycles got %0d exp 20", n); end
      checks++; if (alert_ack !== 4'b1000) begin errors++; $display("FAIL rr_tmo_ack got %b exp 1000", alert_ack); end
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rr_mode_frozen got %0d exp 0", mode); end
      alert_req = 4'b0000;
      step();
      checks++; if (disp_mode !== 2'd0 || alert_ack !== 4'b0) begin
         errors++; $display("FAIL rr_idle got disp %0d ack %b exp disp 0 ack 0000", disp_mode, alert_ack); end
   endtask

   task automatic test_key_and_alert();
      press(3'd1); press(3'd1); press(3'd1);
      key_val = 3'd1; alert_req = 4'b0100;
      step();
      key_val = 3'd0;
      checks++; if (mode !== 2'd0 || mode_chg !== 1'b1) begin
         errors++; $display("FAIL ka_mode got %0d chg %b exp 0 chg 1", mode, mode_chg); end
      checks++; if (disp_mode !== 2'd2) begin errors++; $display("FAIL ka_disp got %0d exp 2", disp_mode); end
      step();
      press(3'd1);
      checks++; if (alert_ack !== 4'b0100) begin errors++; $display("FAIL ka_ack got %b exp 0100", alert_ack); end
      checks++; if (mode !== 2'd0 || mode_chg !== 1'b0 || disp_mode !== 2'd0) begin
         errors++; $display("FAIL ka_after got mode %0d chg %b disp %0d exp 0 0 0", mode, mode_chg, disp_mode); end
      alert_req = 4'b0000;
      step();
   endtask

   task automatic test_req_drop();
      alert_req = 4'b0100;
      step();
      checks++; if (disp_mode !== 2'd2) begin errors++; $display("FAIL drop_grant got %0d exp 2", disp_mode); end
      step(); step();
      alert_req = 4'b0000;
      step();
      checks++; if (disp_mode !== 2'd0 || blink !== 1'b0 || alert_ack !== 4'b0) begin
         errors++; $display("FAIL drop_ret got disp %0d blink %b ack %b exp 0 0 0000", disp_mode, blink, alert_ack); end
      step();
      checks++; if (alert_ack !== 4'b0) begin errors++; $display("FAIL drop_noack got %b exp 0000", alert_ack); end
   endtask

   task automatic test_reset_mid_alert();
      press(3'd1);
      alert_req = 4'b1000;
      step();
      checks++; if (disp_mode !== 2'd3 || mode !== 2'd1) begin
         errors++; $display("FAIL mr_pre got disp %0d mode %0d exp 3 1", disp_mode, mode); end
      step();
      rst = 1'b0;
      #1;
      checks++; if ({key_route, data_out, mode, disp_mode, mode_chg, alert_ack, blink} !== 43'd0) begin
         errors++; $display("FAIL mr_async got %h exp 0", {key_route, data_out, mode, disp_mode, mode_chg, alert_ack, blink}); end
      alert_req = 4'b0000;
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (alert_ack !== 4'b0 || mode !== 2'd0) begin
            errors++; $display("FAIL mr_noack got ack %b mode %0d exp 0000 0", alert_ack, mode); end
      end
   endtask

`ifdef MODE_LOCK_EN
   task automatic test_lock();
      lock = 4'b0001;
      press(3'd1);
      checks++; if (key_route !== 12'h001 || mode !== 2'd0 || mode_chg !== 1'b0) begin
         errors++; $display("FAIL lock_fwd got route %h mode %0d chg %b exp 001 0 0", key_route, mode, mode_chg); end
      step();
      lock = 4'b0000;
      press(3'd1);
      checks++; if (mode !== 2'd1 || mode_chg !== 1'b1) begin
         errors++; $display("FAIL lock_off got mode %0d chg %b exp 1 1", mode, mode_chg); end
   endtask
`endif

   initial begin
      test_reset();
      test_mode_advance();
      test_key_route();
      test_alert_rr();
      test_key_and_alert();
      test_req_drop();
      test_reset_mid_alert();
`ifdef MODE_LOCK_EN
      test_lock();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
